mem_arbiter: RTL and testbench

- Shares one single-port data memory between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Latches one requester's command, drives the memory's request/address/w_data/masking/we_re interface, and waits for the memory's one-cycle-late valid.
- Returns a registered ack, read data and timeout error to the winning requester.
- Sits between the core's fetch/LSU and the memory wrapper. Only one transaction is outstanding at a time.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between fetch (port 0)
// and LSU (port 1); one transaction in flight, all outputs registered.
module mem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int TIMEOUT        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_mask,
    input  logic              p0_we,
    output logic              p0_ack,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_mask,
    input  logic              p1_we,
    output logic              p1_ack,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_w_data,
    output logic [3:0]        mem_masking,
    output logic              mem_we_re,
    input  logic              mem_valid,
    input  logic [31:0]       mem_r_data,
    output logic              busy,
    output logic              grant_id
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mask_q, mask_d;
    logic              we_q, we_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              pick, done, tmo;

    // Next-state and registered-output computation for the whole FSM
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        we_d         = we_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        mem_req_d    = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        done         = 1'b0;
        tmo          = 1'b0;
        pick         = 1'b0;
        if (p0_req && p1_req) begin
            pick = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else begin
            pick = p1_req;
        end
        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = pick ? p1_addr : p0_addr;
                    wdata_d      = pick ? p1_wdata : p0_wdata;
                    mask_d       = pick ? p1_mask : p0_mask;
                    we_d         = pick ? p1_we : p0_we;
                    mem_req_d    = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    done = 1'b1;
                    if (!we_q) begin
                        if (grant_q) rdata1_d = mem_r_data;
                        else         rdata0_d = mem_r_data;
                    end
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    done = 1'b1;
                    tmo  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (done) begin
            state_d = RESP;
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
            err0_d  = ~grant_q & tmo;
            err1_d  = grant_q & tmo;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            we_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            mem_req_q    <= mem_req_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            we_q         <= we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign p0_ack      = ack0_q;
    assign p0_rdata    = rdata0_q;
    assign p0_err      = err0_q;
    assign p1_ack      = ack1_q;
    assign p1_rdata    = rdata1_q;
    assign p1_err      = err1_q;
    assign mem_request = mem_req_q;
    assign mem_address = addr_q;
    assign mem_w_data  = wdata_q;
    assign mem_masking = mask_q;
    assign mem_we_re   = we_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural
// memory and a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [7:0]  p0_addr = 0, p1_addr = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0;
    logic [3:0]  p0_mask = 0, p1_mask = 0;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_request, mem_we_re, mem_valid, busy, grant_id;
    logic [7:0]  mem_address;
    logic [31:0] mem_w_data, mem_r_data;
    logic [3:0]  mem_masking;

    mem_arbiter #(.ADDR_W(8), .FIXED_PRIORITY(1'b0), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_mask(p0_mask), .p0_we(p0_we), .p0_ack(p0_ack),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_mask(p1_mask), .p1_we(p1_we), .p1_ack(p1_ack),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_request(mem_request), .mem_address(mem_address),
        .mem_w_data(mem_w_data), .mem_masking(mem_masking),
        .mem_we_re(mem_we_re), .mem_valid(mem_valid),
        .mem_r_data(mem_r_data), .busy(busy), .grant_id(grant_id)
    );

    // Fixed-priority instance with its own trivial memory
    logic        f_p0_req = 0, f_p1_req = 0;
    logic [7:0]  f_p0_addr = 8'h11, f_p1_addr = 8'h22;
    logic        f_p0_ack, f_p1_ack, f_p0_err, f_p1_err;
    logic [31:0] f_p0_rdata, f_p1_rdata;
    logic        f_req, f_we, f_busy, f_gid;
    logic [7:0]  f_addr;
    logic [31:0] f_wd;
    logic [3:0]  f_msk;
    logic        f_mv = 1'b0;
    logic [31:0] f_rd = '0;

    mem_arbiter #(.ADDR_W(8), .FIXED_PRIORITY(1'b1), .TIMEOUT(8)) u_fp (
        .clk(clk), .rst(rst),
        .p0_req(f_p0_req), .p0_addr(f_p0_addr), .p0_wdata(32'h0),
        .p0_mask(4'h0), .p0_we(1'b0), .p0_ack(f_p0_ack),
        .p0_rdata(f_p0_rdata), .p0_err(f_p0_err),
        .p1_req(f_p1_req), .p1_addr(f_p1_addr), .p1_wdata(32'h0),
        .p1_mask(4'h0), .p1_we(1'b0), .p1_ack(f_p1_ack),
        .p1_rdata(f_p1_rdata), .p1_err(f_p1_err),
        .mem_request(f_req), .mem_address(f_addr),
        .mem_w_data(f_wd), .mem_masking(f_msk),
        .mem_we_re(f_we), .mem_valid(f_mv),
        .mem_r_data(f_rd), .busy(f_busy), .grant_id(f_gid)
    );

    always @(posedge clk) begin
        f_mv <= f_req;
        f_rd <= {24'h0, f_addr};
    end

    // Behavioural memory: valid one cycle after request; low nibble F unmapped
    function automatic logic mapped(input logic [7:0] a);
        return a[3:0] != 4'hF;
    endfunction

    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h3C, 8'h5A};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    logic [31:0] mem [256] = '{default: 32'h0};
    logic        touched [256] = '{default: 1'b0};
    logic        mv_q = 1'b0;
    logic        inject = 1'b0;
    logic [31:0] rd_q = '0;
    logic [31:0] cur;

    assign cur        = touched[mem_address] ? mem[mem_address] : init_word(mem_address);
    assign mem_valid  = mv_q | inject;
    assign mem_r_data = rd_q;

    always @(posedge clk) begin
        mv_q <= mem_request && mapped(mem_address);
        rd_q <= mem_request ? cur : 32'hBAD0BAD0;
        if (mem_request && mem_we_re && mapped(mem_address)) begin
            mem[mem_address]     <= merge(cur, mem_w_data, mem_masking);
            touched[mem_address] <= 1'b1;
        end
    end

    // Reference model and scoreboard
    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [31:0] shadow [int];
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    int          tests = 0, fails = 0, cyc = 0;
    int          ack_ports[$], ack_cyc[$];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic predict(input int port, input logic [7:0] a,
                           input logic w, input logic [31:0] d,
                           input logic [3:0] m, output exp_t e);
        logic [31:0] old;
        old = shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
        e.addr = a; e.we = w; e.wdata = d; e.mask = m;
        e.err = !mapped(a);
        if (mapped(a) && w) shadow[int'(a)] = merge(old, d, m);
        if (mapped(a) && !w) last_rd[port] = old;
        e.rdata = last_rd[port];
    endtask

    task automatic drive(input int port, input logic r, input logic [7:0] a,
                         input logic w, input logic [31:0] d,
                         input logic [3:0] m);
        if (port == 0) begin
            p0_req = r; p0_addr = a; p0_we = w; p0_wdata = d; p0_mask = m;
        end else begin
            p1_req = r; p1_addr = a; p1_we = w; p1_wdata = d; p1_mask = m;
        end
    endtask

    task automatic do_txn(input int port, input logic [7:0] a,
                          input logic w, input logic [31:0] d,
                          input logic [3:0] m, output int lat);
        exp_t e;
        int   n_other;
        logic got;
        n_other = 0;
        got = 1'b0;
        predict(port, a, w, d, m, e);
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
        drive(port, 1'b1, a, w, d, m);
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = (port == 0) ? p0_ack : p1_ack;
            if (!got && ((port == 0) ? p1_ack : p0_ack)) n_other++;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL no_ack port %0d: no ack within %0d cycles", port, lat);
        end
        check($sformatf("fairness_p%0d", port), 128'(n_other > 1), 128'(0));
        drive(port, 1'b0, a, w, d, m);
    endtask

    // Monitor: pops expectations on ack, checks mem-side command on request
    initial begin
        exp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_req = 1'b0;
            end else begin
                if (p0_ack | p1_ack) begin
                    check("dual_ack", 128'(p0_ack & p1_ack), 128'(0));
                    ack_ports.push_back(p1_ack ? 1 : 0);
                    ack_cyc.push_back(cyc);
                end
                if (p0_ack) begin
                    if (q0.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL p0_spurious_ack: ack=1 required 0");
                    end else begin
                        e = q0.pop_front();
                        check("p0_rdata", 128'(p0_rdata), 128'(e.rdata));
                        check("p0_err", 128'(p0_err), 128'(e.err));
                    end
                end
                if (p1_ack) begin
                    if (q1.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL p1_spurious_ack: ack=1 required 0");
                    end else begin
                        e = q1.pop_front();
                        check("p1_rdata", 128'(p1_rdata), 128'(e.rdata));
                        check("p1_err", 128'(p1_err), 128'(e.err));
                    end
                end
                if (mem_request) begin
                    check("req_pulse", 128'(prev_req), 128'(0));
                    check("busy_issue", 128'(busy), 128'(1));
                    if ((grant_id ? q1.size() : q0.size()) == 0) begin
                        tests++; fails++;
                        $display("FAIL mem_cmd: request with no pending cmd for port %0d", grant_id);
                    end else begin
                        e = grant_id ? q1[0] : q0[0];
                        check("mem_cmd",
                              128'({mem_address, mem_we_re, mem_w_data, mem_masking}),
                              128'({e.addr, e.we, e.wdata, e.mask}));
                    end
                end
                prev_req = mem_request;
            end
        end
    end

    task automatic check_reset_outs(input string name);
        check(name, 128'({p0_ack, p0_rdata, p0_err, p1_ack, p1_rdata, p1_err,
                          mem_request, mem_address, mem_w_data, mem_masking,
                          mem_we_re, busy, grant_id}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, n0, n1;
        logic got;
        exp_t e;
        #2 rst = 1'b0;
        #1 check_reset_outs("reset_outputs");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Contention: both ports request back-to-back, round-robin
        ack_ports.delete();
        ack_cyc.delete();
        fork
            begin
                int l;
                for (int k = 0; k < 3; k++)
                    do_txn(0, 8'(k + 1), 1'b0, 32'h0, 4'h0, l);
            end
            begin
                int l;
                for (int k = 0; k < 3; k++)
                    do_txn(1, 8'(k + 8'h81), 1'b0, 32'h0, 4'h0, l);
            end
        join
        check("rr_count", 128'(ack_ports.size()), 128'(6));
        for (int i = 0; i < ack_ports.size(); i++)
            check($sformatf("rr_order_%0d", i), 128'(ack_ports[i]), 128'(i % 2));
        for (int i = 1; i < ack_cyc.size(); i++)
            check($sformatf("rr_gap_%0d", i), 128'(ack_cyc[i] - ack_cyc[i-1]), 128'(4));
        @(negedge clk);

        // Single read with nominal latency
        do_txn(0, 8'h10, 1'b0, 32'h0, 4'h0, lat);
        check("p0_read_latency", 128'(lat), 128'(3));
        @(negedge clk);

        // Write then read back on port 1, plus a partial-mask write
        do_txn(1, 8'h20, 1'b1, 32'hA5A5A5A5, 4'hF, lat);
        check("p1_write_latency", 128'(lat), 128'(3));
        do_txn(1, 8'h20, 1'b0, 32'h0, 4'h0, lat);
        do_txn(1, 8'h20, 1'b1, 32'h12345678, 4'h5, lat);
        do_txn(1, 8'h20, 1'b0, 32'h0, 4'h0, lat);
        check("p1_partial_mask_rdata", 128'(p1_rdata), 128'(32'hA534A578));
        @(negedge clk);

        // Timeout with no memory response, then a late valid in IDLE
        do_txn(0, 8'h1F, 1'b0, 32'h0, 4'h0, lat);
        check("timeout_latency", 128'(lat), 128'(10));
        @(negedge clk);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        check("late_valid_rdata", 128'(p0_rdata), 128'(last_rd[0]));
        check("late_valid_busy", 128'(busy), 128'(0));

        // Reset in the middle of WAIT
        predict(0, 8'h2F, 1'b0, 32'h0, 4'h0, e);
        q0.push_back(e);
        drive(0, 1'b1, 8'h2F, 1'b0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 128'(busy), 128'(1));
        #2 rst = 1'b0;
        #1 check_reset_outs("midwait_reset_outputs");
        q0.delete();
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        drive(0, 1'b0, 8'h2F, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("post_reset_idle", 128'({busy, p0_ack, p1_ack}), 128'(0));
        do_txn(0, 8'h10, 1'b0, 32'h0, 4'h0, lat);
        check("post_reset_latency", 128'(lat), 128'(3));

        // Randomised traffic, disjoint address halves per port
        fork
            begin
                int l;
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_txn(0, {1'b0, 7'($urandom)}, 1'($urandom), $urandom,
                           4'($urandom), l);
                end
            end
            begin
                int l;
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_txn(1, {1'b1, 7'($urandom)}, 1'($urandom), $urandom,
                           4'($urandom), l);
                end
            end
        join
        repeat (4) @(negedge clk);
        check("queues_drained", 128'(q0.size() + q1.size()), 128'(0));

        // Fixed priority: port 0 keeps winning while it holds req
        n0 = 0;
        n1 = 0;
        f_p0_req = 1'b1;
        f_p1_req = 1'b1;
        for (int k = 0; k < 60 && n0 < 4; k++) begin
            @(negedge clk);
            if (f_p0_ack) n0++;
            if (f_p1_ack) n1++;
        end
        f_p0_req = 1'b0;
        check("fp_p0_grants", 128'(n0), 128'(4));
        check("fp_p1_held_off", 128'(n1), 128'(0));
        check("fp_p0_rdata", 128'({f_p0_err, f_p0_rdata}), 128'(32'h11));
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = f_p1_ack;
        end
        check("fp_p1_after_drop", 128'(got), 128'(1));
        check("fp_p1_rdata", 128'({f_p1_err, f_p1_rdata}), 128'(32'h22));
        f_p1_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
